arc4_ksa_param: RTL and testbench

- Parametrised ARC4 key-scheduling engine: optional identity fill of the S array (S[k]=k) followed by the full KSA swap loop.
- Key length and S-array depth are generic.
- Drives an external single-port synchronous S memory.
- Handshakes with the top-level controller via rdy/en. Sits between the task-level FSM and the S RAM, ahead of the PRGA stage.

---
 rtl/arc4_ksa_param.sv | 133 +++++++++++++
 tb/tb_arc4_ksa_param.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_ksa_param.sv
// ARC4 key-scheduling engine: optional identity fill of S, then the KSA swap loop,
// driving an external single-port synchronous S memory.
module arc4_ksa_param #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   do_init,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   rdy,
  output logic                   done,
  output logic [ADDR_W-1:0]      addr,
  input  logic [ADDR_W-1:0]      rddata,
  output logic [ADDR_W-1:0]      wrdata,
  output logic                   wren
);

  // state    | meaning
  // IDLE     | ready, waiting for en
  // INIT     | identity fill, one write per cycle
  // K_RD_I   | present S[i] address
  // K_WAIT_I | capture S[i] into si
  // K_RD_J   | update j, present S[j] address
  // K_WAIT_J | capture S[j] into sj
  // K_WR_I   | S[i] <= sj
  // K_WR_J   | S[j] <= si, advance i/kc or finish
  // DONE     | one-cycle completion pulse
  typedef enum logic [3:0] {
    IDLE, INIT, K_RD_I, K_WAIT_I, K_RD_J, K_WAIT_J, K_WR_I, K_WR_J, DONE
  } state_t;

  localparam int KC_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] I_LAST  = '1;
  localparam logic [KC_W-1:0]   KC_LAST = KC_W'(KEY_BYTES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] i, j, si, sj;
  logic [ADDR_W-1:0] kval, j_nxt;
  logic [KC_W-1:0]   kc;
  logic [7:0]        key_arr [KEY_BYTES];

  // Key bytes are truncated or zero-extended to the S data width.
  assign kval  = ADDR_W'(key_arr[kc]);
  assign j_nxt = j + si + kval;

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    done      = 1'b0;
    addr      = '0;
    wrdata    = '0;
    wren      = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_nxt = do_init ? INIT : K_RD_I;
      end
      INIT: begin
        addr   = i;
        wrdata = i;
        wren   = 1'b1;
        if (i == I_LAST) state_nxt = K_RD_I;
      end
      K_RD_I: begin
        addr      = i;
        state_nxt = K_WAIT_I;
      end
      K_WAIT_I: state_nxt = K_RD_J;
      K_RD_J: begin
        addr      = j_nxt;
        state_nxt = K_WAIT_J;
      end
      K_WAIT_J: state_nxt = K_WR_I;
      K_WR_I: begin
        addr      = i;
        wrdata    = sj;
        wren      = 1'b1;
        state_nxt = K_WR_J;
      end
      K_WR_J: begin
        addr      = j;
        wrdata    = si;
        wren      = 1'b1;
        state_nxt = (i == I_LAST) ? DONE : K_RD_I;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
      kc    <= '0;
      for (int b = 0; b < KEY_BYTES; b++) key_arr[b] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (en) begin
            i  <= '0;
            j  <= '0;
            kc <= '0;
            for (int b = 0; b < KEY_BYTES; b++)
              key_arr[b] <= key[8*(KEY_BYTES-1-b) +: 8];
          end
        end
        // natural wrap returns i to 0 after the last fill entry
        INIT:     i  <= i + 1'b1;
        K_WAIT_I: si <= rddata;
        K_RD_J:   j  <= j_nxt;
        K_WAIT_J: sj <= rddata;
        K_WR_J: begin
          if (i != I_LAST) begin
            i  <= i + 1'b1;
            kc <= (kc == KC_LAST) ? '0 : kc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_ksa_param.sv
// Bench for arc4_ksa_param: behavioural S memories, a plain-arithmetic ARC4 KSA
// reference, and per-scenario tasks checking S contents, latency and pulses.
module tb_arc4_ksa_param;
  localparam int D = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, en = 1'b0, do_init = 1'b0;
  logic [23:0] key = '0;
  logic        rdy, done, wren;
  logic [7:0]  addr, rddata, wrdata;

  logic         en_s = 1'b0, do_init_s = 1'b0;
  logic [7:0]   key1 = '0;
  logic [39:0]  key5 = '0;
  logic [127:0] key16 = '0;
  logic         rdy1, rdy5, rdy16, done1, done5, done16, wren1, wren5, wren16;
  logic [7:0]   addr1, rddata1, wrdata1, addr16, rddata16, wrdata16;
  logic [3:0]   addr5, rddata5, wrdata5;

  logic [7:0] mem3 [256];
  logic [7:0] m1   [256];
  logic [3:0] m5   [16];
  logic [7:0] m16  [256];
  logic [1:0] fill = 2'd0;

  int vectors = 0, miscompares = 0;
  int gold [256];
  int gkey [32];
  int r_lat, r_dcyc, r_ndone, r_nwr, r_first_wr, r_id_bad;

  arc4_ksa_param #(.KEY_BYTES(3), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .do_init(do_init), .key(key), .rdy(rdy), .done(done),
    .addr(addr), .rddata(rddata), .wrdata(wrdata), .wren(wren));
  arc4_ksa_param #(.KEY_BYTES(1), .ADDR_W(8)) dut1 (
    .clk(clk), .rst(rst), .en(en_s), .do_init(do_init_s), .key(key1), .rdy(rdy1), .done(done1),
    .addr(addr1), .rddata(rddata1), .wrdata(wrdata1), .wren(wren1));
  arc4_ksa_param #(.KEY_BYTES(5), .ADDR_W(4)) dut5 (
    .clk(clk), .rst(rst), .en(en_s), .do_init(do_init_s), .key(key5), .rdy(rdy5), .done(done5),
    .addr(addr5), .rddata(rddata5), .wrdata(wrdata5), .wren(wren5));
  arc4_ksa_param #(.KEY_BYTES(16), .ADDR_W(8)) dut16 (
    .clk(clk), .rst(rst), .en(en_s), .do_init(do_init_s), .key(key16), .rdy(rdy16), .done(done16),
    .addr(addr16), .rddata(rddata16), .wrdata(wrdata16), .wren(wren16));

  // fill: 1 = identity preload, 2 = random garbage
  always @(posedge clk) begin
    if (fill == 2'd1) for (int k = 0; k < 256; k++) mem3[k] <= 8'(k);
    else if (fill == 2'd2) for (int k = 0; k < 256; k++) mem3[k] <= 8'($urandom);
    else if (wren) mem3[addr] <= wrdata;
    rddata <= mem3[addr];
  end
  always @(posedge clk) begin
    if (fill == 2'd2) for (int k = 0; k < 256; k++) m1[k] <= 8'($urandom);
    else if (wren1) m1[addr1] <= wrdata1;
    rddata1 <= m1[addr1];
  end
  always @(posedge clk) begin
    if (fill == 2'd2) for (int k = 0; k < 16; k++) m5[k] <= 4'($urandom);
    else if (wren5) m5[addr5] <= wrdata5;
    rddata5 <= m5[addr5];
  end
  always @(posedge clk) begin
    if (fill == 2'd2) for (int k = 0; k < 256; k++) m16[k] <= 8'($urandom);
    else if (wren16) m16[addr16] <= wrdata16;
    rddata16 <= m16[addr16];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Textbook ARC4 KSA over S of 'depth' entries; key bytes reduced mod depth.
  task automatic golden_ksa(input int depth, input int klen);
    int jj, t;
    for (int k = 0; k < depth; k++) gold[k] = k;
    jj = 0;
    for (int ii = 0; ii < depth; ii++) begin
      jj = (jj + gold[ii] + (gkey[ii % klen] % depth)) % depth;
      t = gold[ii]; gold[ii] = gold[jj]; gold[jj] = t;
    end
  endtask

  task automatic gold24(input logic [23:0] kv);
    gkey[0] = int'(kv[23:16]);
    gkey[1] = int'(kv[15:8]);
    gkey[2] = int'(kv[7:0]);
    golden_ksa(D, 3);
  endtask

  function automatic int mem3_bad();
    int b = 0;
    for (int k = 0; k < D; k++) if (mem3[k] !== 8'(gold[k])) b++;
    return b;
  endfunction

  task automatic fill_mem(input logic [1:0] mode);
    @(negedge clk); fill = mode;
    @(negedge clk); fill = 2'd0;
  endtask

  // Returns just after the accept edge.
  task automatic start3(input bit init, input logic [23:0] kv);
    int n = 0;
    @(negedge clk);
    while (rdy !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    vectors++;
    if (rdy !== 1'b1) begin
      $display("FAIL start_wait: rdy=%b required 1", rdy); miscompares++;
    end
    key = kv; do_init = init; en = 1'b1;
    @(posedge clk);
  endtask

  // Cycle 1 is the cycle following the accept edge.
  task automatic run3(input bit init, input logic [23:0] kv, input int pulse_a, input int pulse_b);
    start3(init, kv);
    r_lat = -1; r_dcyc = -1; r_ndone = 0; r_nwr = 0; r_first_wr = -1; r_id_bad = -1;
    for (int n = 1; n <= 20000; n++) begin
      @(negedge clk);
      if (n == pulse_a || n == pulse_b) begin
        en = 1'b1; key = 24'($urandom); do_init = ~init;
      end else en = 1'b0;
      if (wren === 1'b1) begin r_nwr++; if (r_first_wr < 0) r_first_wr = n; end
      if (done === 1'b1) begin r_ndone++; r_dcyc = n; end
      if (init && n == D + 1) begin
        r_id_bad = 0;
        for (int k = 0; k < D; k++) if (mem3[k] !== 8'(k)) r_id_bad++;
      end
      if (rdy === 1'b1) begin r_lat = n; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 6;
    if (rdy !== 1'b1)   begin $display("FAIL reset_rdy: got %b want 1", rdy); miscompares++; end
    if (done !== 1'b0)  begin $display("FAIL reset_done: got %b want 0", done); miscompares++; end
    if (wren !== 1'b0)  begin $display("FAIL reset_wren: got %b want 0", wren); miscompares++; end
    if (addr !== 8'h00) begin $display("FAIL reset_addr: got %h want 00", addr); miscompares++; end
    if (wrdata !== 8'h00) begin $display("FAIL reset_wrdata: got %h want 00", wrdata); miscompares++; end
    if ({rdy1, rdy5, rdy16} !== 3'b111) begin
      $display("FAIL reset_sweep_rdy: got %b want 111", {rdy1, rdy5, rdy16}); miscompares++;
    end
    rst = 1'b0;
  endtask

  task automatic test_identity_fill();
    fill_mem(2'd2);
    run3(1'b1, 24'h000000, -1, -1);
    gold24(24'h000000);
    vectors += 7;
    if (r_id_bad !== 0) begin $display("FAIL identity_fill: %0d bad entries want 0", r_id_bad); miscompares++; end
    if (mem3_bad() !== 0) begin $display("FAIL idfill_final_s: %0d bad entries want 0", mem3_bad()); miscompares++; end
    if (r_lat !== 1794) begin $display("FAIL idfill_latency: got %0d want 1794", r_lat); miscompares++; end
    if (r_dcyc !== 1793) begin $display("FAIL idfill_done_cycle: got %0d want 1793", r_dcyc); miscompares++; end
    if (r_ndone !== 1) begin $display("FAIL idfill_done_count: got %0d want 1", r_ndone); miscompares++; end
    if (r_nwr !== 3*D) begin $display("FAIL idfill_writes: got %0d want %0d", r_nwr, 3*D); miscompares++; end
    if (r_first_wr !== 1) begin $display("FAIL idfill_first_write: got %0d want 1", r_first_wr); miscompares++; end
  endtask

  task automatic test_ksa_only();
    fill_mem(2'd1);
    run3(1'b0, 24'h000102, -1, -1);
    gold24(24'h000102);
    vectors += 5;
    if (mem3_bad() !== 0) begin $display("FAIL ksa_only_s: %0d bad entries want 0", mem3_bad()); miscompares++; end
    if (r_lat !== 1538) begin $display("FAIL ksa_only_latency: got %0d want 1538", r_lat); miscompares++; end
    if (r_dcyc !== 1537) begin $display("FAIL ksa_only_done_cycle: got %0d want 1537", r_dcyc); miscompares++; end
    if (r_first_wr !== 5) begin $display("FAIL ksa_only_first_write: got %0d want 5", r_first_wr); miscompares++; end
    if (r_nwr !== 2*D) begin $display("FAIL ksa_only_writes: got %0d want %0d", r_nwr, 2*D); miscompares++; end
  endtask

  task automatic test_random_keys();
    logic [23:0] kv;
    for (int t = 0; t < 3; t++) begin
      kv = 24'($urandom);
      fill_mem(2'd2);
      run3(1'b1, kv, -1, -1);
      gold24(kv);
      vectors += 2;
      if (mem3_bad() !== 0) begin
        $display("FAIL rand_key_s key=%h: %0d bad entries want 0", kv, mem3_bad()); miscompares++;
      end
      if (r_lat !== 1794) begin $display("FAIL rand_key_latency: got %0d want 1794", r_lat); miscompares++; end
    end
  endtask

  task automatic test_back_to_back();
    int rdy_cyc [2];
    int done_cyc [2];
    int nrdy = 0, ndone = 0, bad1 = -1;
    fill_mem(2'd2);
    start3(1'b1, 24'h0000D6);
    for (int n = 1; n <= 8000; n++) begin
      @(negedge clk);
      if (n == 1) key = 24'h00033C;
      if (nrdy == 1 && n == rdy_cyc[0] + 1) en = 1'b0;
      if (done === 1'b1) begin if (ndone < 2) done_cyc[ndone] = n; ndone++; end
      if (rdy === 1'b1) begin
        if (nrdy < 2) rdy_cyc[nrdy] = n;
        nrdy++;
        if (nrdy == 1) begin gold24(24'h0000D6); bad1 = mem3_bad(); end
        else break;
      end
    end
    en = 1'b0;
    gold24(24'h00033C);
    vectors += 6;
    if (bad1 !== 0) begin $display("FAIL b2b_s_first: %0d bad entries want 0", bad1); miscompares++; end
    if (mem3_bad() !== 0) begin $display("FAIL b2b_s_second: %0d bad entries want 0", mem3_bad()); miscompares++; end
    if (nrdy !== 2) begin $display("FAIL b2b_rdy_count: got %0d want 2", nrdy); miscompares++; end
    if (ndone !== 2) begin $display("FAIL b2b_done_count: got %0d want 2", ndone); miscompares++; end
    if (nrdy == 2 && (rdy_cyc[0] !== 1794 || rdy_cyc[1] !== 3588)) begin
      $display("FAIL b2b_rdy_cycles: got %0d,%0d want 1794,3588", rdy_cyc[0], rdy_cyc[1]); miscompares++;
    end
    if (ndone == 2 && (done_cyc[0] !== 1793 || done_cyc[1] !== 3587)) begin
      $display("FAIL b2b_done_cycles: got %0d,%0d want 1793,3587", done_cyc[0], done_cyc[1]); miscompares++;
    end
  endtask

  task automatic test_reset_midrun();
    logic [23:0] kv;
    fill_mem(2'd2);
    start3(1'b1, 24'($urandom));
    for (int n = 1; n <= 700; n++) begin
      @(negedge clk);
      en = 1'b0;
      if (n == 700) rst = 1'b1;
    end
    @(negedge clk);
    vectors += 4;
    if (rdy !== 1'b1)  begin $display("FAIL midrst_rdy: got %b want 1", rdy); miscompares++; end
    if (wren !== 1'b0) begin $display("FAIL midrst_wren: got %b want 0", wren); miscompares++; end
    if (done !== 1'b0) begin $display("FAIL midrst_done: got %b want 0", done); miscompares++; end
    if (addr !== 8'h00) begin $display("FAIL midrst_addr: got %h want 00", addr); miscompares++; end
    rst = 1'b0;
    kv = 24'($urandom);
    run3(1'b1, kv, -1, -1);
    gold24(kv);
    vectors += 2;
    if (mem3_bad() !== 0) begin $display("FAIL midrst_rerun_s: %0d bad entries want 0", mem3_bad()); miscompares++; end
    if (r_lat !== 1794) begin $display("FAIL midrst_rerun_latency: got %0d want 1794", r_lat); miscompares++; end
  endtask

  task automatic test_ignored_start();
    logic [23:0] kv;
    kv = 24'($urandom);
    fill_mem(2'd2);
    run3(1'b1, kv, 10, 1000);
    gold24(kv);
    vectors += 4;
    if (mem3_bad() !== 0) begin $display("FAIL ignored_en_s: %0d bad entries want 0", mem3_bad()); miscompares++; end
    if (r_lat !== 1794) begin $display("FAIL ignored_en_latency: got %0d want 1794", r_lat); miscompares++; end
    if (r_ndone !== 1) begin $display("FAIL ignored_en_done_count: got %0d want 1", r_ndone); miscompares++; end
    if (r_nwr !== 3*D) begin $display("FAIL ignored_en_writes: got %0d want %0d", r_nwr, 3*D); miscompares++; end
  endtask

  task automatic test_param_sweep();
    int lat1 = -1, lat5 = -1, lat16 = -1, bad;
    fill_mem(2'd2);
    @(negedge clk);
    key1 = 8'($urandom);
    key5 = {8'($urandom), 32'($urandom)};
    key16 = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    en_s = 1'b1; do_init_s = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      en_s = 1'b0;
      if (rdy1 === 1'b1 && lat1 < 0) lat1 = n;
      if (rdy5 === 1'b1 && lat5 < 0) lat5 = n;
      if (rdy16 === 1'b1 && lat16 < 0) lat16 = n;
      if (lat1 >= 0 && lat5 >= 0 && lat16 >= 0) break;
    end
    vectors += 6;
    if (lat1 !== 1794) begin $display("FAIL sweep_kb1_latency: got %0d want 1794", lat1); miscompares++; end
    if (lat5 !== 114) begin $display("FAIL sweep_kb5_aw4_latency: got %0d want 114", lat5); miscompares++; end
    if (lat16 !== 1794) begin $display("FAIL sweep_kb16_latency: got %0d want 1794", lat16); miscompares++; end
    gkey[0] = int'(key1);
    golden_ksa(256, 1);
    bad = 0;
    for (int k = 0; k < 256; k++) if (m1[k] !== 8'(gold[k])) bad++;
    if (bad !== 0) begin $display("FAIL sweep_kb1_s: %0d bad entries want 0", bad); miscompares++; end
    for (int b = 0; b < 5; b++) gkey[b] = int'(key5[8*(4-b) +: 8]);
    golden_ksa(16, 5);
    bad = 0;
    for (int k = 0; k < 16; k++) if (m5[k] !== 4'(gold[k])) bad++;
    if (bad !== 0) begin $display("FAIL sweep_kb5_aw4_s: %0d bad entries want 0", bad); miscompares++; end
    for (int b = 0; b < 16; b++) gkey[b] = int'(key16[8*(15-b) +: 8]);
    golden_ksa(256, 16);
    bad = 0;
    for (int k = 0; k < 256; k++) if (m16[k] !== 8'(gold[k])) bad++;
    if (bad !== 0) begin $display("FAIL sweep_kb16_s: %0d bad entries want 0", bad); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_identity_fill();
    test_ksa_only();
    test_random_keys();
    test_back_to_back();
    test_reset_midrun();
    test_ignored_start();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
